// File: rtl/sd_wr_buf_pkg.sv
// rtl/sd_wr_buf_pkg.sv - shared constants and read-FSM encoding for sd_wr_buf
package sd_wr_buf_pkg;

    localparam int DATA_NUM = 256;          // 16-bit words per SD sector
    localparam int PTR_W    = 8;            // word pointer within one bank
    localparam int RAM_AW   = PTR_W + 1;    // {bank, ptr}

    typedef enum logic [2:0] {
        RD_IDLE  = 3'd0,
        RD_START = 3'd1,
        RD_WAIT  = 3'd2,
        RD_XFER  = 3'd3,
        RD_DONE  = 3'd4
    } rd_state_t;

endpackage

// File: rtl/sd_wr_dpram.sv
// rtl/sd_wr_dpram.sv - 512x16 simple dual-port RAM with registered read
//
// Purpose: ping-pong sector storage, addressed as {bank, ptr}.
// Ports:
//   clk, rst_n      clock and async active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read port; rdata updates the cycle after re
//   rdata           registered read data, 0 after reset
module sd_wr_dpram
    import sd_wr_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [RAM_AW-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [0:2*DATA_NUM-1];
    logic [15:0] rdata_d;
    logic [15:0] rdata_q;

    // Storage itself is not reset; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sd_wr_buf.sv
// rtl/sd_wr_buf.sv - UART byte stream to SD sector write buffer (ping-pong)
//
// Purpose: packs received bytes big-endian into 16-bit words, fills two
// 256-word banks alternately and hands each full bank to the SD write stage.
// Optional feature macro: SD_WR_BUF_FLUSH_EN (adds the flush input, which
// zero-pads a partially filled bank and queues it for writing).
// Ports:
//   sys_clk, sys_rst_n   clock, async active-low reset
//   init_end             SD card ready; gates the start of a sector write
//   rx_valid, rx_data    byte strobe and byte from the UART receiver
//   wr_busy, wr_req      SD write stage status and per-word request
//   flush                (SD_WR_BUF_FLUSH_EN only) pad and close the fill bank
//   wr_en                one-cycle sector write start
//   wr_addr              sector address for the current write
//   wr_data              word offered to the SD write stage
//   overflow             sticky, a byte was dropped
//   sector_cnt           sectors completed since reset
module sd_wr_buf
    import sd_wr_buf_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        wr_busy,
    input  logic        wr_req,
`ifdef SD_WR_BUF_FLUSH_EN
    input  logic        flush,
`endif
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        overflow,
    output logic [31:0] sector_cnt
);

    // Fill side
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             fill_bank_q, fill_bank_d;
    logic             phase_hi_q, phase_hi_d;
    logic [7:0]       hi_byte_q, hi_byte_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       ready_q, ready_d;
    logic             mark_ready;
`ifdef SD_WR_BUF_FLUSH_EN
    logic             pad_q, pad_d;
`endif

    // Drain side
    rd_state_t        state_q, state_d;
    logic             drain_bank_q, drain_bank_d;
    logic [PTR_W:0]   rd_cnt_q, rd_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [31:0]      sector_cnt_q, sector_cnt_d;
    logic             rd_release;

    // RAM ports
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic              mem_re;
    logic [RAM_AW-1:0] mem_waddr;
    logic [RAM_AW-1:0] mem_raddr;

    assign mem_waddr = {fill_bank_q, wr_ptr_q};
    assign mem_raddr = {drain_bank_q, rd_cnt_q[PTR_W-1:0]};

    sd_wr_dpram u_dpram (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (wr_data)
    );

    // Byte packing and bank filling. A READY fill bank covers both "full and
    // waiting" and "being drained", since READY is only cleared in RD_DONE;
    // that also drops a byte arriving in the release cycle itself.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_bank_d = fill_bank_q;
        phase_hi_d  = phase_hi_q;
        hi_byte_d   = hi_byte_q;
        overflow_d  = overflow_q;
        mem_we      = 1'b0;
        mem_wdata   = {hi_byte_q, rx_data};
        mark_ready  = 1'b0;
`ifdef SD_WR_BUF_FLUSH_EN
        pad_d       = pad_q;
        if (pad_q) begin
            // First pad word carries a pending odd byte, the rest are zero.
            mem_we     = 1'b1;
            mem_wdata  = phase_hi_q ? 16'h0000 : {hi_byte_q, 8'h00};
            phase_hi_d = 1'b1;
            if (rx_valid) begin
                overflow_d = 1'b1;
            end
        end else if (flush && !ready_q[fill_bank_q] &&
                     ((wr_ptr_q != '0) || !phase_hi_q)) begin
            pad_d = 1'b1;
            if (rx_valid) begin
                overflow_d = 1'b1;
            end
        end else
`endif
        if (rx_valid) begin
            if (ready_q[fill_bank_q]) begin
                overflow_d = 1'b1;
            end else if (phase_hi_q) begin
                hi_byte_d  = rx_data;
                phase_hi_d = 1'b0;
            end else begin
                mem_we     = 1'b1;
                phase_hi_d = 1'b1;
            end
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            // Wrap from 255 closes the bank and moves filling to the other one.
            if (&wr_ptr_q) begin
                mark_ready  = 1'b1;
                fill_bank_d = ~fill_bank_q;
`ifdef SD_WR_BUF_FLUSH_EN
                pad_d       = 1'b0;
`endif
            end
        end
    end

    // Read FSM
    always_comb begin
        state_d      = state_q;
        drain_bank_d = drain_bank_q;
        rd_cnt_d     = rd_cnt_q;
        sector_cnt_d = sector_cnt_q;
        wr_addr_d    = wr_addr_q;
        mem_re       = 1'b0;
        rd_release   = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (ready_q[drain_bank_q] && init_end && !wr_busy) begin
                    state_d   = RD_START;
                    // Latched on entry so it is already valid alongside wr_en.
                    wr_addr_d = BASE_ADDR + sector_cnt_q;
                end
            end
            RD_START: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (wr_busy) begin
                    state_d = RD_XFER;
                end
            end
            RD_XFER: begin
                // rd_cnt MSB set means all 256 words have been read.
                if (wr_req && !rd_cnt_q[PTR_W]) begin
                    mem_re   = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (!wr_busy) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                rd_release   = 1'b1;
                sector_cnt_d = sector_cnt_q + 32'd1;
                drain_bank_d = ~drain_bank_q;
                rd_cnt_d     = '0;
                state_d      = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        wr_en_d = (state_d == RD_START);

        // Fill and release never target the same bank in one cycle: the fill
        // bank can only be marked when not READY, the drain bank is READY.
        ready_d = ready_q;
        if (rd_release) begin
            ready_d[drain_bank_q] = 1'b0;
        end
        if (mark_ready) begin
            ready_d[fill_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q     <= '0;
            fill_bank_q  <= 1'b0;
            phase_hi_q   <= 1'b1;
            hi_byte_q    <= 8'h00;
            overflow_q   <= 1'b0;
            ready_q      <= 2'b00;
            state_q      <= RD_IDLE;
            drain_bank_q <= 1'b0;
            rd_cnt_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= BASE_ADDR;
            sector_cnt_q <= 32'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_bank_q  <= fill_bank_d;
            phase_hi_q   <= phase_hi_d;
            hi_byte_q    <= hi_byte_d;
            overflow_q   <= overflow_d;
            ready_q      <= ready_d;
            state_q      <= state_d;
            drain_bank_q <= drain_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            sector_cnt_q <= sector_cnt_d;
        end
    end

`ifdef SD_WR_BUF_FLUSH_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= pad_d;
        end
    end
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign overflow   = overflow_q;
    assign sector_cnt = sector_cnt_q;

endmodule

// File: tb/tb_sd_wr_buf.sv
// tb/tb_sd_wr_buf.sv - scoreboard testbench for sd_wr_buf
module tb_sd_wr_buf;

    localparam logic [31:0] BASE = 32'd1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        wr_busy;
    logic        wr_req;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        overflow;
    logic [31:0] sector_cnt;
`ifdef SD_WR_BUF_FLUSH_EN
    logic        flush;
`endif

    always #5 sys_clk = ~sys_clk;

    sd_wr_buf #(.BASE_ADDR(BASE)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .init_end   (init_end),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .wr_busy    (wr_busy),
        .wr_req     (wr_req),
`ifdef SD_WR_BUF_FLUSH_EN
        .flush      (flush),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .overflow   (overflow),
        .sector_cnt (sector_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected words and sector addresses, in order.
    logic [15:0] exp_words[$];
    logic [31:0] exp_addrs[$];

    // Reference model: byte pairing, sector count, occupancy.
    bit          m_phase_hi;
    logic [7:0]  m_hi;
    int          m_words;
    int          m_sectors;
    int          m_filled;
    bit          m_ovf;

    // SD write stage model state.
    int          sd_done = 0;
    int          done_off = 0;
    int          sd_word_idx = 0;
    bit          sd_hold = 1'b0;
    bit          sd_abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_words.delete();
        exp_addrs.delete();
        m_phase_hi = 1'b1;
        m_hi       = 8'h00;
        m_words    = 0;
        m_sectors  = 0;
        m_filled   = 0;
        m_ovf      = 1'b0;
        done_off   = sd_done;
    endtask

    // Two full sectors not yet released means the fill bank is busy.
    task automatic model_byte(input logic [7:0] b);
        if (m_filled - (sd_done - done_off) >= 2) begin
            m_ovf = 1'b1;
        end else if (m_phase_hi) begin
            m_hi       = b;
            m_phase_hi = 1'b0;
        end else begin
            exp_words.push_back({m_hi, b});
            m_phase_hi = 1'b1;
            m_words++;
            if (m_words % 256 == 0) begin
                exp_addrs.push_back(BASE + 32'(m_sectors));
                m_sectors++;
                m_filled++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        model_byte(b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge sys_clk);
    endtask

    task automatic send_n(input int n, input bit ramp);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = ramp ? i[7:0] : 8'($urandom);
            send_byte(b);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (((sd_done - done_off) != m_filled || exp_words.size() != 0) && n < 6000) begin
            @(negedge sys_clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 6000), 32'd1);
        check({name, "_sector_cnt"}, sector_cnt, 32'(m_filled));
        check({name, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    // SD write stage model and output monitor.
    task automatic do_sector();
        logic [31:0] a;
        logic [15:0] w;
        logic [15:0] last;
        sd_word_idx = 0;
        last = 16'h0000;
        if (exp_addrs.size() == 0) begin
            check("wr_en_unexpected", {31'd0, wr_en}, 32'd0);
            a = 32'hFFFF_FFFF;
        end else begin
            a = exp_addrs.pop_front();
        end
        check("wr_addr", wr_addr, a);
        @(posedge sys_clk);
        #1;
        wr_busy = 1'b1;
        wr_req  = 1'b1;   // lands in RD_WAIT and must be ignored
        @(negedge sys_clk);
        check("wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
        @(posedge sys_clk);
        #1;
        wr_req = 1'b0;
        for (int i = 0; i < 256 && !sd_abort; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge sys_clk);
            @(posedge sys_clk);
            #1;
            wr_req = 1'b1;
            @(posedge sys_clk);
            #1;
            wr_req = 1'b0;
            @(negedge sys_clk);
            w = (exp_words.size() != 0) ? exp_words.pop_front() : 16'hxxxx;
            last = w;
            check("wr_data", {16'd0, wr_data}, {16'd0, w});
            sd_word_idx = i + 1;
        end
        if (sd_abort) begin
            return;
        end
        @(posedge sys_clk);
        #1;
        wr_req = 1'b1;
        @(posedge sys_clk);
        #1;
        wr_req = 1'b0;
        @(negedge sys_clk);
        check("wr_data_saturate", {16'd0, wr_data}, {16'd0, last});
        check("wr_addr_stable", wr_addr, a);
        @(posedge sys_clk);
        #1;
        wr_busy = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sd_done++;
    endtask

    initial begin
        wr_busy = 1'b0;
        wr_req  = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (wr_en === 1'b1 && !sd_abort) begin
                do_sector();
            end else begin
                wr_busy = sd_hold;
            end
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int k;
        sys_rst_n = 1'b0;
        init_end  = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
`ifdef SD_WR_BUF_FLUSH_EN
        flush     = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", wr_addr, BASE);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_sector_cnt", sector_cnt, 32'd0);
        sys_rst_n = 1'b1;

        // Ramp 0x00..0xFF twice: one sector at BASE, words 0001..FEFF.
        send_n(512, 1'b1);
        wait_drain("ramp");

        // Three sectors of random bytes streamed while draining.
        send_n(1536, 1'b0);
        wait_drain("stream");

        // Both banks full with init_end low: no write until it rises.
        init_end = 1'b0;
        send_n(1024, 1'b0);
        seen = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (wr_en === 1'b1) seen++;
        end
        check("no_wr_en_init_low", 32'(seen), 32'd0);
        init_end = 1'b1;
        k = 0;
        while (wr_en !== 1'b1 && k < 5) begin
            @(negedge sys_clk);
            k++;
        end
        check("init_end_latency", 32'(k >= 1 && k <= 2), 32'd1);
        wait_drain("init_gate");

        // SD stage held busy: 1025th byte overflows, later bytes land cleanly.
        sd_hold = 1'b1;
        send_n(1024, 1'b0);
        check("overflow_at_1024", {31'd0, overflow}, 32'd0);
        send_n(1, 1'b0);
        check("overflow_at_1025", {31'd0, overflow}, 32'd1);
        sd_hold = 1'b0;
        k = 0;
        while ((sd_done - done_off) < m_filled - 1 && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        check("first_release", 32'(k < 3000), 32'd1);
        send_n(512, 1'b0);
        wait_drain("held");

        // Reset in the middle of a transfer.
        send_n(512, 1'b0);
        k = 0;
        while (!(exp_addrs.size() == 0 && sd_word_idx >= 64) && k < 4000) begin
            @(negedge sys_clk);
            k++;
        end
        check("reached_mid_xfer", 32'(k < 4000), 32'd1);
        sd_hold  = 1'b1;
        sd_abort = 1'b1;
        repeat (8) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_rst_wr_addr", wr_addr, BASE);
        check("mid_rst_wr_data", {16'd0, wr_data}, 32'd0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        check("mid_rst_sector_cnt", sector_cnt, 32'd0);
        model_reset();
        repeat (2) @(negedge sys_clk);
        sd_abort = 1'b0;
        sd_hold  = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_n(512, 1'b0);
        wait_drain("after_rst");
        check("after_rst_wr_addr", wr_addr, BASE);

`ifdef SD_WR_BUF_FLUSH_EN
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        @(negedge sys_clk);
        flush = 1'b1;
        if (!m_phase_hi) begin
            exp_words.push_back({m_hi, 8'h00});
            m_words++;
            m_phase_hi = 1'b1;
        end
        while (m_words % 256 != 0) begin
            exp_words.push_back(16'h0000);
            m_words++;
        end
        exp_addrs.push_back(BASE + 32'(m_sectors));
        m_sectors++;
        m_filled++;
        @(negedge sys_clk);
        flush = 1'b0;
        wait_drain("flush");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
